// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/multdiv_if.sv
// Operand/start/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(
  parameter int WIDTH = multdiv_pkg::WIDTH
);

  logic signed [WIDTH-1:0] data_operandA;
  logic signed [WIDTH-1:0] data_operandB;
  logic                    ctrl_MULT;
  logic                    ctrl_DIV;
  logic signed [WIDTH-1:0] data_result;
  logic                    data_exception;
  logic                    data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and the final result sign.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             neg,
  output logic [WIDTH-1:0] dataOut
);

  assign dataOut = neg ? (~dataIn + 1'b1) : dataIn;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one step per clock.
module multdiv_unit #(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int ITERS = multdiv_pkg::ITERS
) (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);

  import multdiv_pkg::*;

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  // 2^(WIDTH-1): largest magnitude that still fits a negative result
  localparam logic [2*WIDTH-1:0] MAG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state;
  logic [CW-1:0]           counter;
  logic signed [WIDTH-1:0] resultQ;
  logic                    excQ;
  logic                    rdyQ;

  logic                    start;
  logic                    lastStep;
  logic [WIDTH-1:0]        absA;
  logic [WIDTH-1:0]        absB;
  logic [WIDTH-1:0]        rawMag;
  logic [WIDTH-1:0]        signedMag;
  logic signed [WIDTH-1:0] opResult;
  logic                    opExc;

  logic                    opMul;
  logic                    negRes;
  logic                    bZero;
  logic [2*WIDTH-1:0]      acc;
  logic [2*WIDTH-1:0]      mcand;
  logic [WIDTH:0]          mplier;
  logic [WIDTH:0]          divisor;
  logic [WIDTH:0]          rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH+1:0]        remShift;
  logic [WIDTH+1:0]        diff;
  logic                    take;
  logic                    mulExc;
  logic                    divExc;

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign lastStep = (counter == CW'(ITERS - 1));

  mdu_negate #(.WIDTH(WIDTH)) uNegA (
    .dataIn (bus.data_operandA),
    .neg    (bus.data_operandA[WIDTH-1]),
    .dataOut(absA)
  );

  mdu_negate #(.WIDTH(WIDTH)) uNegB (
    .dataIn (bus.data_operandB),
    .neg    (bus.data_operandB[WIDTH-1]),
    .dataOut(absB)
  );

  // Restoring divide step: remainder never reaches 2^WIDTH, so the top bit of diff is the borrow
  assign remShift = {rem, quo[WIDTH-1]};
  assign diff     = remShift - {1'b0, divisor};
  assign take     = ~diff[WIDTH+1];

  // Operand stage: latch magnitudes and signs on start, then one iteration per clock
  always_ff @(posedge clock) begin
    if (start) begin
      opMul   <= bus.ctrl_MULT;
      negRes  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      bZero   <= (bus.data_operandB == '0);
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, absA};
      mplier  <= {1'b0, absB};
      divisor <= {1'b0, absB};
      rem     <= '0;
      quo     <= absA;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == DIV) begin
      rem <= take ? diff[WIDTH:0] : remShift[WIDTH:0];
      quo <= {quo[WIDTH-2:0], take};
    end
  end

  // Result stage: apply sign and classify the exception from the final magnitudes
  assign rawMag = opMul ? acc[WIDTH-1:0] : quo;

  mdu_negate #(.WIDTH(WIDTH)) uNegRes (
    .dataIn (rawMag),
    .neg    (negRes),
    .dataOut(signedMag)
  );

  assign mulExc   = negRes ? (acc > MAG_LIMIT) : (acc >= MAG_LIMIT);
  assign divExc   = bZero | (~negRes & quo[WIDTH-1]);
  assign opExc    = opMul ? mulExc : divExc;
  assign opResult = (!opMul && bZero) ? '0 : signed'(signedMag);

  // A new start takes priority in every state, so an aborted operation never reaches DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      resultQ <= '0;
      excQ    <= 1'b0;
      rdyQ    <= 1'b0;
    end else begin
      rdyQ <= 1'b0;
      if (start) begin
        state   <= bus.ctrl_MULT ? MUL : DIV;
        counter <= '0;
      end else begin
        case (state)
          MUL, DIV: begin
            counter <= counter + 1'b1;
            if (lastStep) begin
              state   <= DONE;
              counter <= '0;
            end
          end
          DONE: begin
            resultQ <= opResult;
            excQ    <= opExc;
            rdyQ    <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = resultQ;
  assign bus.data_exception = excQ;
  assign bus.data_resultRDY = rdyQ;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table plus restart/priority/reset sequences.
module tb_multdiv_unit;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rdySeen = 0;

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_unit #(.WIDTH(W), .ITERS(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          mul;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    bit          exc;
    int          due;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Independent reference using native 64-bit signed arithmetic
  function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint p;
    logic [31:0] lo;
    if (mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'($signed(lo)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == multdiv_pkg::INT_MIN && b == 32'hFFFF_FFFF) begin
      r = multdiv_pkg::INT_MIN;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  // Scoreboard consumer: every RDY pulse must match the oldest pending expectation
  always @(negedge clock) begin
    if (bus.data_resultRDY) begin
      rdySeen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got rdy=1 at cycle %0d, want no pending result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, bus.data_result, e.res);
        check({e.name, "_exc"}, {31'd0, bus.data_exception}, {31'd0, e.exc});
        check({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  task automatic startOp(input bit mul, input bit div, input logic [31:0] a,
                         input logic [31:0] b, output int c0);
    @(negedge clock);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    c0 = cyc;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic expectAt(input logic [31:0] res, input bit exc, input int due, input string name);
    exp_t e;
    e.res  = res;
    e.exc  = exc;
    e.due  = due;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input logic [31:0] heldRes);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, sb.size());
      sb.delete();
    end
    @(negedge clock);
    check({name, "_held"}, bus.data_result, heldRes);
    check({name, "_rdy_low"}, {31'd0, bus.data_resultRDY}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          seen;
    logic [31:0] r;
    bit          e;
    vec_t        v;

    vecs.push_back('{1, 0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, "mul_7xm6"});
    vecs.push_back('{1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, "mul_ovf_pos"});
    vecs.push_back('{1, 0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 0, "mul_min_x1"});
    vecs.push_back('{1, 0, 32'hFFFF_8000, 32'h0001_0000, 32'h8000_0000, 0, "mul_neg_edge"});
    vecs.push_back('{1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "mul_min_xm1"});
    vecs.push_back('{1, 0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mul_zero"});
    vecs.push_back('{0, 1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 0, "div_m100_7"});
    vecs.push_back('{0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, "div_100_m7"});
    vecs.push_back('{0, 1, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 0, "div_0_5"});
    vecs.push_back('{0, 1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1, "div_by_zero"});
    vecs.push_back('{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_min_m1"});
    vecs.push_back('{0, 1, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 0, "div_7_2"});
    for (int i = 0; i < 6; i++) begin
      v.mul  = i[0];
      v.div  = ~i[0];
      v.a    = $urandom;
      v.b    = (i < 2) ? 32'($urandom_range(0, 65535)) : $urandom;
      model(v.mul, v.a, v.b, r, e);
      v.res  = r;
      v.exc  = e;
      v.name = $sformatf("rand%0d", i);
      vecs.push_back(v);
    end

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", {31'd0, bus.data_exception}, 32'd0);
    check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      startOp(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, c0);
      expectAt(vecs[i].res, vecs[i].exc, c0 + LAT, vecs[i].name);
      drain(vecs[i].name, vecs[i].res);
    end

    // Restart mid-multiply with a divide: only the divide may report
    startOp(1, 0, 32'd3, 32'd3, c0);
    repeat (9) @(posedge clock);
    startOp(0, 1, 32'd20, 32'd3, c0);
    expectAt(32'd6, 1'b0, c0 + LAT, "restart_div");
    drain("restart_div", 32'd6);

    startOp(1, 1, 32'd4, 32'd2, c0);
    expectAt(32'd8, 1'b0, c0 + LAT, "mul_priority");
    drain("mul_priority", 32'd8);

    // Reset during a multiply clears outputs and suppresses its RDY
    startOp(1, 0, 32'd7, 32'd5, c0);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_result", bus.data_result, 32'd0);
    check("midreset_exc", {31'd0, bus.data_exception}, 32'd0);
    check("midreset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    reset = 1'b0;
    seen = rdySeen;
    repeat (40) @(negedge clock);
    check("midreset_no_rdy", rdySeen, seen);

    startOp(1, 0, 32'd2, 32'd3, c0);
    expectAt(32'd6, 1'b0, c0 + LAT, "post_reset_mul");
    drain("post_reset_mul", 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
